// File: rtl/alu_pkg.sv
// Shared definitions for the SIMD execute-stage ALU: opcodes, FSM states and
// the lane-wise add/sub helper used by the packed-lane ops.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_MUL   = 4'b0100;
  localparam logic [3:0] ALU_DIVU  = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_PADD  = 4'b1000;
  localparam logic [3:0] ALU_PADDS = 4'b1001;
  localparam logic [3:0] ALU_PSUB  = 4'b1010;
  localparam logic [3:0] ALU_PSUBS = 4'b1011;
  localparam logic [3:0] ALU_SLL   = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;
  localparam logic [3:0] ALU_SRL   = 4'b1110;
  localparam logic [3:0] ALU_SRA   = 4'b1111;

  // Widest lane the helper below can handle.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    is_iter = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  // One lane of width 'lane' (operands zero-extended into MAXW bits).
  // Saturating add clamps to all ones on carry-out; saturating sub floors at 0.
  function automatic logic [MAXW-1:0] lane_addsub(input logic [MAXW-1:0] a,
                                                  input logic [MAXW-1:0] b,
                                                  input int lane,
                                                  input logic sub,
                                                  input logic sat);
    logic [MAXW:0] mask;
    logic [MAXW:0] s;
    mask = ((MAXW+1)'(1) << lane) - (MAXW+1)'(1);
    if (sub) s = {1'b0, a} - {1'b0, b};
    else     s = {1'b0, a} + {1'b0, b};
    if (sat && !sub && (s > mask))    s = mask;
    else if (sat && sub && (a < b))   s = '0;
    lane_addsub = s[MAXW-1:0] & mask[MAXW-1:0];
  endfunction

endpackage

// File: rtl/simd_alu_mc_if.sv
// Operand/result bus of the SIMD ALU; master is the issuing pipeline stage.
interface simd_alu_mc_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] srcA;
  logic [W-1:0] srcB;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, srcA, srcB, ALUControl, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, srcA, srcB, ALUControl, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// done/value are combinational on the final step so the caller can register them.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] value
);
  localparam int CW = $clog2(W) + 1;

  logic [CW-1:0] cnt;
  logic          is_mul;
  logic          is_rem;
  // p: product accumulator or partial remainder; q: multiplier or quotient;
  // m: shifting multiplicand or divisor.
  logic [W-1:0]  p, q, m;
  logic [W-1:0]  p_n, q_n, m_n;
  logic [W:0]    r_sh;

  always_comb begin
    p_n  = p;
    q_n  = q;
    m_n  = m;
    r_sh = '0;
    if (is_mul) begin
      if (q[0]) p_n = p + m;
      m_n = m << 1;
      q_n = q >> 1;
    end else begin
      r_sh = {p, q[W-1]};
      if (r_sh >= {1'b0, m}) begin
        p_n = W'(r_sh - {1'b0, m});
        q_n = {q[W-2:0], 1'b1};
      end else begin
        p_n = r_sh[W-1:0];
        q_n = {q[W-2:0], 1'b0};
      end
    end
  end

  assign done  = (cnt == CW'(1));
  assign value = (is_mul || is_rem) ? p_n : q_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
      p      <= '0;
      q      <= '0;
      m      <= '0;
    end else if (start) begin
      cnt    <= CW'(W);
      is_mul <= (op == ALU_MUL);
      is_rem <= (op == ALU_REMU);
      p      <= '0;
      q      <= (op == ALU_MUL) ? b : a;
      m      <= (op == ALU_MUL) ? a : b;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      p   <= p_n;
      q   <= q_n;
      m   <= m_n;
    end
  end
endmodule

// File: rtl/simd_alu_mc.sv
// Execute-stage ALU: single-cycle scalar/packed-lane ops plus iterative mul/div,
// behind a valid/ready handshake with a registered result.
module simd_alu_mc
  import alu_pkg::*;
#(
  parameter int W    = 32,
  parameter int LANE = 8
) (
  input  logic         clk,
  input  logic         reset,
  simd_alu_mc_if.slave bus,
  output state_t       dbg_state
);
  localparam int SW     = $clog2(W);
  localparam int NLANES = W / LANE;

  // Handshake: an op transfers on a cycle where in_valid && in_ready; a result
  // transfers where out_valid && out_ready, and stays unchanged until then.
  state_t       state, state_n;
  logic         in_ready, accept, start, res_load;
  logic [W-1:0] result, res_n, single;
  logic         zero;
  logic         md_done;
  logic [W-1:0] md_value;
  logic [SW-1:0] shamt;

  alu_iter_muldiv #(.W(W)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (bus.ALUControl),
    .a     (bus.srcA),
    .b     (bus.srcB),
    .done  (md_done),
    .value (md_value)
  );

  always_comb begin
    single = '0;
    shamt  = bus.srcA[SW-1:0];
    case (bus.ALUControl)
      ALU_ADD: single = bus.srcA + bus.srcB;
      ALU_SUB: single = bus.srcA - bus.srcB;
      ALU_AND: single = bus.srcA & bus.srcB;
      ALU_OR:  single = bus.srcA | bus.srcB;
      ALU_XOR: single = bus.srcA ^ bus.srcB;
      ALU_SLT: single = {{(W-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      ALU_SLL: single = bus.srcB << shamt;
      ALU_SRL: single = bus.srcB >> shamt;
      ALU_SRA: single = $signed(bus.srcB) >>> shamt;
      // Opcode bit 1 selects subtract, bit 0 selects saturation.
      ALU_PADD, ALU_PADDS, ALU_PSUB, ALU_PSUBS: begin
        for (int i = 0; i < NLANES; i++) begin
          single[i*LANE +: LANE] = LANE'(lane_addsub(
            {{(MAXW-LANE){1'b0}}, bus.srcA[i*LANE +: LANE]},
            {{(MAXW-LANE){1'b0}}, bus.srcB[i*LANE +: LANE]},
            LANE, bus.ALUControl[1], bus.ALUControl[0]));
        end
      end
      default: single = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    res_load = 1'b0;
    res_n    = result;
    in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    accept   = bus.in_valid && in_ready;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (is_iter(bus.ALUControl)) begin
            start   = 1'b1;
            state_n = CALC;
          end else begin
            res_load = 1'b1;
            res_n    = single;
            state_n  = DONE;
          end
        end else if ((state == DONE) && bus.out_ready) begin
          state_n = IDLE;
        end
      end
      CALC: begin
        if (md_done) begin
          res_load = 1'b1;
          res_n    = md_value;
          state_n  = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_n;
      if (res_load) begin
        result <= res_n;
        zero   <= (res_n == '0);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CALC);
  assign bus.result    = result;
  assign bus.zero      = zero;
  assign dbg_state     = state;
endmodule

// File: tb/tb_simd_alu_mc.sv
// Directed bench for simd_alu_mc: vector table plus backpressure, streaming
// and reset-during-multiply sequences.
module tb_simd_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simd_alu_mc_if #(.W(W)) bus ();
  state_t dbg_state;

  simd_alu_mc #(.W(W), .LANE(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op (block must be ready), then waits a bounded time for out_valid.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.srcA       = a;
    bus.srcB       = b;
    bus.out_ready  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_cnt++;
      step();
      lat++;
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int lat, bc;
    logic [W-1:0] e;

    vecs.push_back(vec_t'{ALU_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SUB,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1});
    vecs.push_back(vec_t'{ALU_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_OR,    32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_XOR,   32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    vecs.push_back(vec_t'{ALU_SLL,   32'h0000_0004, 32'h0000_00F1, 32'h0000_0F10, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SRL,   32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SRA,   32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SRA,   32'h0000_0024, 32'hF000_0000, 32'hFF00_0000, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_SRA,   32'h0000_001F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_PADD,  32'hFF01_8080, 32'h0102_8080, 32'h0003_0000, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_PADDS, 32'hFF10_80F0, 32'h0120_8020, 32'hFF30_FFFF, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_PSUB,  32'h0005_0010, 32'h0106_0001, 32'hFFFF_000F, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_PSUBS, 32'h0510_0000, 32'h0620_0001, 32'h0000_0000, 1'b1, 1});
    vecs.push_back(vec_t'{ALU_PSUBS, 32'h0510_8005, 32'h0208_7F01, 32'h0308_0104, 1'b0, 1});
    vecs.push_back(vec_t'{ALU_MUL,   32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, W+1});
    vecs.push_back(vec_t'{ALU_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, W+1});
    vecs.push_back(vec_t'{ALU_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, W+1});
    vecs.push_back(vec_t'{ALU_REMU,  32'd100,       32'd7,         32'd2,         1'b0, W+1});
    vecs.push_back(vec_t'{ALU_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, W+1});
    vecs.push_back(vec_t'{ALU_REMU,  32'd5,         32'd0,         32'd5,         1'b0, W+1});
    vecs.push_back(vec_t'{ALU_DIVU,  32'd7,         32'd100,       32'd0,         1'b1, W+1});
    vecs.push_back(vec_t'{ALU_DIVU,  32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 1'b0, W+1});
    vecs.push_back(vec_t'{ALU_REMU,  32'hFFFF_FFFF, 32'd10,        32'd5,         1'b0, W+1});

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.srcA       = '0;
    bus.srcB       = '0;
    bus.ALUControl = '0;

    // Reset state
    step();
    step();
    check("rst_out_valid", W'(bus.out_valid), 0);
    check("rst_result",    bus.result,        0);
    check("rst_zero",      W'(bus.zero),      1);
    check("rst_busy",      W'(bus.busy),      0);
    check("rst_in_ready",  W'(bus.in_ready),  1);
    check("rst_state",     W'(dbg_state),     W'(IDLE));
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
      check($sformatf("v%0d_result", i),  bus.result, vecs[i].exp);
      check($sformatf("v%0d_zero", i),    W'(bus.zero), W'(vecs[i].z));
      check($sformatf("v%0d_busy_cycles", i), W'(bc), (vecs[i].lat > 1) ? W'(W) : W'(0));
    end

    // Backpressure: result held in DONE while out_ready=0, pending op not taken
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid   = 1'b1;
    bus.ALUControl = ALU_ADD;
    bus.srcA       = 32'd3;
    bus.srcB       = 32'd4;
    bus.out_ready  = 1'b0;
    step();
    bus.srcA = 32'd10;
    bus.srcB = 32'd1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp%0d_out_valid", k), W'(bus.out_valid), 1);
      check($sformatf("bp%0d_result", k),    bus.result,        32'd7);
      check($sformatf("bp%0d_in_ready", k),  W'(bus.in_ready),  0);
      step();
    end

    // Stream four adds, one result per cycle
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_valid = 1'b1;
      bus.srcA     = W'(10 * k);
      bus.srcB     = W'(k);
      exp_q.push_back(W'(11 * k));
      step();
      e = exp_q.pop_front();
      check($sformatf("stream%0d_out_valid", k), W'(bus.out_valid), 1);
      check($sformatf("stream%0d_result", k),    bus.result,        e);
    end
    bus.in_valid = 1'b0;

    // Reset during a multiply
    bus.in_valid   = 1'b1;
    bus.ALUControl = ALU_MUL;
    bus.srcA       = 32'h0000_1234;
    bus.srcB       = 32'h0000_0010;
    step();
    bus.in_valid = 1'b0;
    check("calc_busy",     W'(bus.busy),     1);
    check("calc_in_ready", W'(bus.in_ready), 0);
    check("calc_state",    W'(dbg_state),    W'(CALC));
    for (int k = 0; k < 9; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_out_valid", W'(bus.out_valid), 0);
    check("abort_result",    bus.result,        0);
    check("abort_zero",      W'(bus.zero),      1);
    check("abort_in_ready",  W'(bus.in_ready),  1);
    check("abort_busy",      W'(bus.busy),      0);

    // Multiply after abort runs its full length with fresh operands
    run_op(ALU_MUL, 32'h0000_1234, 32'h0000_0010, lat, bc);
    check("post_mul_latency", W'(lat), W'(W + 1));
    check("post_mul_result",  bus.result, 32'h0001_2340);
    run_op(ALU_ADD, 32'd1, 32'd2, lat, bc);
    check("post_add_result",  bus.result, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
